// File: rtl/pea_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pea_pkg
// Description : Shared types and helpers for the PEA result reader slice:
//               reader state encoding, status-word bit layout and the log2
//               helper that sizes the FIFO population ports.
// Revision    : 1.0 - initial release
// ============================================================================
package pea_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        CAPTURE = 2'b10,
        HOLD    = 2'b11
    } state_t;

    // Bit 0 of a status word reads "result valid"; a 0 there marks an error.
    localparam int STATUS_VALID_BIT = 0;

    // Ceiling log2; used for the population port width of the output FIFOs.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pea_result_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : pea_result_reader_if
// Description : Bundle between the result reader and its environment: run
//               control, the paired result/status FIFO read side and the
//               host valid/ready presentation.
//   master : the reader (pops FIFOs, presents pairs, reports busy/done)
//   slave  : the environment (FIFOs, host, run control)
// Optional    : PEA_READER_CHECKSUM_EN adds the checksum signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface pea_result_reader_if #(
    parameter int BUFFER_SIZE_OUT = 32,
    parameter int WIDTH           = 16,
    parameter int CNT_WIDTH       = 8
);
    localparam int POP_W = pea_pkg::log2(BUFFER_SIZE_OUT);

    logic                 start;
    logic [CNT_WIDTH-1:0] expected_count;
    logic [POP_W-1:0]     result_pop;
    logic [POP_W-1:0]     status_pop;
    logic [WIDTH-1:0]     result_data;
    logic [WIDTH-1:0]     status_data;
    logic                 rd_en_result;
    logic                 rd_en_status;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [WIDTH-1:0]     out_status;
    logic [CNT_WIDTH-1:0] out_index;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] err_count;
`ifdef PEA_READER_CHECKSUM_EN
    logic [WIDTH-1:0]     checksum;
`endif

    modport master (
        input  start, expected_count, result_pop, status_pop,
               result_data, status_data, out_ready,
        output rd_en_result, rd_en_status, out_valid, out_result,
               out_status, out_index, busy, done, err_count
`ifdef PEA_READER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, expected_count, result_pop, status_pop,
               result_data, status_data, out_ready,
        input  rd_en_result, rd_en_status, out_valid, out_result,
               out_status, out_index, busy, done, err_count
`ifdef PEA_READER_CHECKSUM_EN
        , input checksum
`endif
    );

endinterface
`default_nettype wire

// File: rtl/pea_pair_popper.sv
`default_nettype none
// ============================================================================
// Module      : pea_pair_popper
// Description : Joint pop of the result and status FIFOs. While armed and both
//               FIFOs hold a word, issues one shared pop strobe; on the
//               following cycle (registered FIFO read data) captures the pair.
// Ports       : clk, rst (async active-low), arm_i, result_pop_i,
//               status_pop_i, result_data_i, status_data_i -> rd_en_o,
//               result_o, status_o
// Revision    : 1.0 - initial release
// ============================================================================
module pea_pair_popper #(
    parameter int POP_W = 5,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm_i,
    input  logic [POP_W-1:0] result_pop_i,
    input  logic [POP_W-1:0] status_pop_i,
    input  logic [WIDTH-1:0] result_data_i,
    input  logic [WIDTH-1:0] status_data_i,
    output logic             rd_en_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] status_o
);
    logic             pop_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] status_q;

    // One strobe feeds both FIFOs so they can never drift apart.
    assign rd_en_o = arm_i && (result_pop_i != '0) && (status_pop_i != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_q    <= 1'b0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            pop_q <= rd_en_o;
            if (pop_q) begin
                result_q <= result_data_i;
                status_q <= status_data_i;
            end
        end
    end

    assign result_o = result_q;
    assign status_o = status_q;

endmodule
`default_nettype wire

// File: rtl/pea_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : pea_result_reader
// Description : Host-side drain of the PEA result/status output FIFOs. A run
//               of expected_count pairs is read one pair at a time, each pair
//               is offered on a valid/ready handshake, error statuses are
//               counted (saturating) and done pulses after the last handshake.
// Ports       : clk, rst (async active-low), bus (pea_result_reader_if.master)
// Optional    : PEA_READER_CHECKSUM_EN - rolling checksum of accepted results,
//               checksum = rotl1(checksum) ^ out_result per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pea_result_reader
    import pea_pkg::*;
#(
    parameter int BUFFER_SIZE_OUT = 32,
    parameter int WIDTH           = 16,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pea_result_reader_if.master   bus
);
    localparam int                   POP_W   = log2(BUFFER_SIZE_OUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0] index_q, index_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
`ifdef PEA_READER_CHECKSUM_EN
    logic [WIDTH-1:0]     csum_q, csum_d;
`endif
    logic                 pop_w;
    logic [WIDTH-1:0]     result_w;
    logic [WIDTH-1:0]     status_w;

    pea_pair_popper #(
        .POP_W (POP_W),
        .WIDTH (WIDTH)
    ) u_popper (
        .clk           (clk),
        .rst           (rst),
        .arm_i         (state_q == WAIT),
        .result_pop_i  (bus.result_pop),
        .status_pop_i  (bus.status_pop),
        .result_data_i (bus.result_data),
        .status_data_i (bus.status_data),
        .rd_en_o       (pop_w),
        .result_o      (result_w),
        .status_o      (status_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            index_q     <= '0;
            err_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PEA_READER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            index_q     <= index_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef PEA_READER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        index_d     = index_q;
        err_d       = err_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
`ifdef PEA_READER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.expected_count;
                    index_d     = '0;
                    err_d       = '0;
`ifdef PEA_READER_CHECKSUM_EN
                    csum_d      = '0;
`endif
                    if (bus.expected_count == '0) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (pop_w) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // FIFO read data is valid this cycle; the popper registers it.
                valid_d = 1'b1;
                if (!bus.status_data[STATUS_VALID_BIT] && (err_q != {CNT_WIDTH{1'b1}})) begin
                    err_d = err_q + CNT_ONE;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    valid_d     = 1'b0;
                    index_d     = index_q + CNT_ONE;
                    remaining_d = remaining_q - CNT_ONE;
`ifdef PEA_READER_CHECKSUM_EN
                    csum_d      = {csum_q[WIDTH-2:0], csum_q[WIDTH-1]} ^ result_w;
`endif
                    if (remaining_q == CNT_ONE) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rd_en_result = pop_w;
    assign bus.rd_en_status = pop_w;
    assign bus.out_valid    = valid_q;
    assign bus.out_result   = result_w;
    assign bus.out_status   = status_w;
    assign bus.out_index    = index_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err_count    = err_q;
`ifdef PEA_READER_CHECKSUM_EN
    assign bus.checksum     = csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pea_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pea_result_reader
// Description : Directed self-checking bench for pea_result_reader with a
//               queue model of the two registered-output FIFOs and a host
//               handshake monitor.
// Optional    : PEA_READER_CHECKSUM_EN enables the checksum cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pea_result_reader;
    import pea_pkg::*;

    localparam int BUF = 32;
    localparam int W   = 16;
    localparam int CW  = 8;
    localparam int PW  = log2(BUF);

    logic clk = 1'b0;
    logic rst = 1'b1;

    pea_result_reader_if #(.BUFFER_SIZE_OUT(BUF), .WIDTH(W), .CNT_WIDTH(CW)) bus ();

    pea_result_reader #(.BUFFER_SIZE_OUT(BUF), .WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model (registered read data) ----------------
    logic [W-1:0] rq[$];
    logic [W-1:0] sq[$];
    logic         wr_r = 1'b0, wr_s = 1'b0;
    logic [W-1:0] wr_r_val = '0, wr_s_val = '0;

    always @(posedge clk) begin
        if (bus.rd_en_result && rq.size() > 0) bus.result_data <= rq.pop_front();
        if (bus.rd_en_status && sq.size() > 0) bus.status_data <= sq.pop_front();
        if (wr_r) rq.push_back(wr_r_val);
        if (wr_s) sq.push_back(wr_s_val);
        bus.result_pop <= PW'(rq.size());
        bus.status_pop <= PW'(sq.size());
    end

    // ---------------- host / strobe monitor ----------------
    int           cyc = 0, hs_n = 0, done_n = 0, rd_n = 0, strobe_mis = 0;
    logic [W-1:0] hs_res [64];
    logic [CW-1:0] hs_idx [64];
    int           hs_cyc [64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.out_valid && bus.out_ready && hs_n < 64) begin
            hs_res[hs_n] <= bus.out_result;
            hs_idx[hs_n] <= bus.out_index;
            hs_cyc[hs_n] <= cyc;
            hs_n         <= hs_n + 1;
        end
        if (bus.done) done_n <= done_n + 1;
        if (bus.rd_en_result) rd_n <= rd_n + 1;
        if (bus.rd_en_result != bus.rd_en_status) strobe_mis <= strobe_mis + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [W-1:0] r, input logic [W-1:0] s,
                             input logic do_r, input logic do_s);
        wr_r = do_r; wr_r_val = r;
        wr_s = do_s; wr_s_val = s;
        @(negedge clk);
        wr_r = 1'b0; wr_s = 1'b0;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        bus.expected_count = n;
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start          = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    int base, d0, r0;
    bit stable;

    initial begin
        bus.start          = 1'b0;
        bus.expected_count = '0;
        bus.out_ready      = 1'b0;
        #1 rst = 1'b0;

        // ---- reset with loaded FIFOs ----
        @(negedge clk);
        push_pair(16'h0011, 16'h0001, 1'b1, 1'b1);
        push_pair(16'h0022, 16'h0001, 1'b1, 1'b1);
        push_pair(16'h0033, 16'h0001, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("rst_valid",  32'(bus.out_valid), 0);
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_done",   32'(bus.done), 0);
        check("rst_err",    32'(bus.err_count), 0);
        check("rst_result", 32'(bus.out_result), 0);
        check("rst_rd_en",  32'(rd_n), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- basic run of 3 pairs ----
        base = hs_n; d0 = done_n;
        bus.out_ready = 1'b1;
        do_start(8'd3);
        wait_done("basic_done_seen");
        repeat (3) @(negedge clk);
        check("basic_hs_count", 32'(hs_n - base), 3);
        check("basic_res0", 32'(hs_res[base]),   32'h0011);
        check("basic_res1", 32'(hs_res[base+1]), 32'h0022);
        check("basic_res2", 32'(hs_res[base+2]), 32'h0033);
        check("basic_idx0", 32'(hs_idx[base]),   0);
        check("basic_idx1", 32'(hs_idx[base+1]), 1);
        check("basic_idx2", 32'(hs_idx[base+2]), 2);
        check("basic_spacing", 32'(hs_cyc[base+1] - hs_cyc[base]), 3);
        check("basic_done_pulses", 32'(done_n - d0), 1);
        check("basic_err", 32'(bus.err_count), 0);
        check("basic_rpop", 32'(bus.result_pop), 0);
        check("basic_spop", 32'(bus.status_pop), 0);
        check("basic_busy", 32'(bus.busy), 0);

        // ---- backpressure ----
        bus.out_ready = 1'b0;
        push_pair(16'h00AA, 16'h0001, 1'b1, 1'b1);
        r0 = rd_n;
        do_start(8'd1);
        wait_valid("bp_valid_seen");
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_result !== 16'h00AA || bus.done) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 1);
        check("bp_pops", 32'(rd_n - r0), 1);
        check("bp_result", 32'(bus.out_result), 32'h00AA);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_done", 32'(bus.done), 1);
        check("bp_valid_drop", 32'(bus.out_valid), 0);
        repeat (2) @(negedge clk);

        // ---- population mismatch stall ----
        push_pair(16'h0101, 16'h0000, 1'b1, 1'b0);
        push_pair(16'h0202, 16'h0000, 1'b1, 1'b0);
        r0 = rd_n; base = hs_n;
        do_start(8'd2);
        repeat (10) @(negedge clk);
        check("stall_busy", 32'(bus.busy), 1);
        check("stall_no_pop", 32'(rd_n - r0), 0);
        check("stall_no_valid", 32'(bus.out_valid), 0);
        push_pair(16'h0000, 16'h0001, 1'b0, 1'b1);
        push_pair(16'h0000, 16'h0001, 1'b0, 1'b1);
        wait_done("stall_done_seen");
        repeat (2) @(negedge clk);
        check("stall_hs_count", 32'(hs_n - base), 2);
        check("stall_res0", 32'(hs_res[base]),   32'h0101);
        check("stall_res1", 32'(hs_res[base+1]), 32'h0202);
        check("stall_rpop", 32'(bus.result_pop), 0);

        // ---- error counting and zero-length run ----
        push_pair(16'h0001, 16'h0000, 1'b1, 1'b1);
        push_pair(16'h0002, 16'h0001, 1'b1, 1'b1);
        push_pair(16'h0003, 16'h0002, 1'b1, 1'b1);
        do_start(8'd3);
        wait_done("err_done_seen");
        check("err_count", 32'(bus.err_count), 2);
        @(negedge clk);
        do_start(8'd0);
        check("zero_done", 32'(bus.done), 1);
        check("zero_busy", 32'(bus.busy), 0);
        check("zero_err_clear", 32'(bus.err_count), 0);
        @(negedge clk);
        check("zero_done_pulse", 32'(bus.done), 0);
        check("zero_busy_after", 32'(bus.busy), 0);

        // ---- reset during HOLD ----
        bus.out_ready = 1'b0;
        push_pair(16'h0055, 16'h0001, 1'b1, 1'b1);
        do_start(8'd1);
        wait_valid("mid_valid_seen");
        rst = 1'b0;
        #1;
        check("mid_valid", 32'(bus.out_valid), 0);
        check("mid_busy", 32'(bus.busy), 0);
        check("mid_result", 32'(bus.out_result), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1;

`ifdef PEA_READER_CHECKSUM_EN
        // ---- checksum ----
        push_pair(16'h0001, 16'h0001, 1'b1, 1'b1);
        push_pair(16'h0002, 16'h0001, 1'b1, 1'b1);
        do_start(8'd2);
        wait_done("csum_a_done_seen");
        check("csum_a", 32'(bus.checksum), 32'h0000);
        @(negedge clk);
        push_pair(16'h8001, 16'h0001, 1'b1, 1'b1);
        push_pair(16'h0010, 16'h0001, 1'b1, 1'b1);
        do_start(8'd2);
        wait_done("csum_b_done_seen");
        check("csum_b", 32'(bus.checksum), 32'h0013);
`endif

        repeat (2) @(negedge clk);
        check("strobe_pairing", 32'(strobe_mis), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pea_result_reader.md
Name: pea_result_reader

Overview:
- Host-side consumer for the PEA output path.
- Drains the paired result and status output FIFOs written by the PEA top module (one word to each per wr_out).
- Presents each result/status pair to the host over a valid/ready handshake, counts error statuses, and signals done after a programmed number of pairs.
- It is the reader counterpart of the command/data writer that loads the PEA input FIFOs.

Parameters:
- buffer_size_out, 32, depth of each output FIFO; population port width is log2(buffer_size_out).
- width, 16, FIFO word width for result and status.
- cnt_width, 8, width of the expected-count, index and error counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; latches expected_count and begins a drain run; ignored while busy.
- expected_count  input  cnt_width  number of pairs to read in this run; 0 means done immediately.
- result_pop  input  log2(buffer_size_out)  population of the result FIFO.
- status_pop  input  log2(buffer_size_out)  population of the status FIFO.
- result_data  input  width  result FIFO read data.
- status_data  input  width  status FIFO read data.
- rd_en_result  output  1  result FIFO pop strobe.
- rd_en_status  output  1  status FIFO pop strobe.
- out_valid  output  1  pair available to the host.
- out_ready  input  1  host accepts the pair.
- out_result  output  width  captured result word.
- out_status  output  width  captured status word.
- out_index  output  cnt_width  0-based index of the presented pair.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when the last pair is accepted.
- err_count  output  cnt_width  number of pairs in this run whose status is an error; saturates.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- FIFO contract: rd_en for one cycle pops one word. Read data is valid on the cycle after rd_en (registered FIFO output).
- States:
  - IDLE: on start, latch expected_count into remaining, clear the index and err_count, set busy. If expected_count == 0, pulse done and stay in IDLE with busy 0. Otherwise go to WAIT.
  - WAIT: when result_pop != 0 and status_pop != 0, assert rd_en_result and rd_en_status together for exactly one cycle, then go to CAPTURE. Never pop one FIFO without the other.
  - CAPTURE: register result_data and status_data into out_result and out_status, set out_valid, update err_count, go to HOLD.
  - HOLD: out_valid stays high and the data stays stable until out_ready. On the handshake cycle (out_valid & out_ready), drop out_valid, increment the index and decrement remaining. If remaining was 1, pulse done, clear busy and go to IDLE; otherwise go to WAIT.
- Throughput: at most one pair per 3 cycles; no back-to-back pops. out_ready held high gives a handshake in the first HOLD cycle.
- Error rule: status is an error when status_data[0] == 0 (bit0 = "result valid"). err_count saturates at all-ones.
- out_index equals the pair count already accepted in this run. It wraps naturally only if cnt_width overflows, which cannot happen because remaining ≤ 2^cnt_width − 1.
- Populations mismatched (one FIFO empty): stay in WAIT indefinitely, with no pop and no timeout.
- start while busy: ignored; latched values are unchanged.
- Reset mid-run: async return to IDLE and all outputs cleared. FIFO contents are untouched; a popped-but-unaccepted pair is lost.

Optional Feature:
- Macro: PEA_READER_CHECKSUM_EN.
- With the macro defined: adds output checksum[width-1:0], cleared on start. On each handshake it is updated to (checksum rotated left by 1) XOR out_result, and it is valid when done pulses.
- Without the macro: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pea_pkg holds:
  - state encodings (IDLE=2'b00, WAIT=2'b01, CAPTURE=2'b10, HOLD=2'b11);
  - STATUS_VALID_BIT = 0;
  - the log2 function used for population widths.
- One natural sub-module: pea_pair_popper. It implements WAIT→CAPTURE: the joint-population check, the single dual pop strobe and the one-cycle-later capture. The top keeps the count/handshake control.

Test Plan:
- Reset/idle: hold rst low with FIFOs loaded → all outputs 0 and no rd_en while in reset.
- Basic run: preload 3 pairs (results 0x0011/0x0022/0x0033, status 0x0001 each), start with expected_count=3, out_ready=1.
  - Expect 3 handshakes with indices 0,1,2, one done pulse, err_count=0.
  - Each FIFO population ends at 0.
- Backpressure: 1 pair, out_ready held low for 10 cycles.
  - out_valid stays high with the data stable and no further pops.
  - done is issued one cycle after out_ready rises.
- Mismatch stall: result FIFO has 2 words, status FIFO has 0 → reader stays in WAIT with no rd_en. Write 2 statuses → both pairs are drained.
- Errors/zero count: statuses 0x0000, 0x0001, 0x0002 → err_count=2.
  - A second start with expected_count=0 gives an immediate done with busy never set.
- Reset mid-HOLD, plus checksum when PEA_READER_CHECKSUM_EN is defined:
  - Drop rst low during HOLD → immediate IDLE, out_valid=0.
  - Checksum case: results 0x0001, 0x0002 → checksum 0x0000 (rotl(0x0001)=0x0002, XOR 0x0002).
